// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. A hit returns the word
// combinationally. A miss stalls the core, reads one 256-bit line from main
// memory through a READ/WAIT/FILL sequence, and then returns to IDLE.
`timescale 1ns/1ps
module instr_cache #(
  parameter int NUM_LINES = 16,
  parameter int BLOCK_AW  = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  output logic [31:0]         out,
  output logic                clk_stall,
  output logic [BLOCK_AW-1:0] mem_block_addr,
  input  logic [255:0]        new_line,
  output logic                readmem
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = BLOCK_AW - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_FILL
  } state_t;

  state_t state, state_next;

  // Address fields
  logic [2:0]          wsel;
  logic [IW-1:0]       idx;
  logic [TW-1:0]       tag;
  logic [BLOCK_AW-1:0] blk;

  assign wsel = addr[4:2];
  assign idx  = addr[IW+4:5];
  assign tag  = addr[BLOCK_AW+4:IW+5];
  assign blk  = addr[BLOCK_AW+4:5];

  // Byte offset and high address bits play no part in the lookup
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:BLOCK_AW+5], addr[1:0]};

  // Line storage
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tags  [NUM_LINES];
  logic [255:0]         lines [NUM_LINES];

  // Miss bookkeeping
  logic [BLOCK_AW-1:0] miss_blk;
  logic [IW-1:0]       miss_idx;
  logic [TW-1:0]       miss_tag;
  logic                latch_miss;
  logic                fill;

  assign miss_idx = miss_blk[IW-1:0];
  assign miss_tag = miss_blk[BLOCK_AW-1:IW];

  // Lookup
  logic         hit;
  logic [255:0] rd_line;
  logic [31:0]  hit_word;
  logic [31:0]  held;

  assign hit      = valid[idx] && (tags[idx] == tag);
  assign rd_line  = lines[idx];
  assign hit_word = rd_line[{wsel, 5'd0} +: 32];
  assign out      = (state == S_IDLE && hit) ? hit_word : held;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and memory-side outputs; reset masks every request so an
  // in-flight miss is abandoned and the stall drops while reset is held
  always_comb begin
    state_next     = state;
    clk_stall      = 1'b0;
    readmem        = 1'b0;
    mem_block_addr = blk;
    latch_miss     = 1'b0;
    fill           = 1'b0;
    case (state)
      S_IDLE: begin
        if (!hit) begin
          clk_stall  = 1'b1;
          latch_miss = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        clk_stall      = 1'b1;
        readmem        = 1'b1;
        mem_block_addr = miss_blk;
        state_next     = S_WAIT;
      end
      S_WAIT: begin
        clk_stall      = 1'b1;
        readmem        = 1'b1;
        mem_block_addr = miss_blk;
        state_next     = S_FILL;
      end
      S_FILL: begin
        clk_stall  = 1'b1;
        fill       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (reset) begin
      clk_stall  = 1'b0;
      readmem    = 1'b0;
      latch_miss = 1'b0;
      fill       = 1'b0;
    end
  end

  // Capture the missing block address so later addr changes cannot redirect the fill
  always_ff @(posedge clk) begin
    if (reset)           miss_blk <= '0;
    else if (latch_miss) miss_blk <= blk;
  end

  // Valid bits: cleared by reset, set when a line is filled
  always_ff @(posedge clk) begin
    if (reset)     valid <= '0;
    else if (fill) valid[miss_idx] <= 1'b1;
  end

  // Tag and data arrays, written only on fill (no reset needed)
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[miss_idx] <= new_line;
      tags[miss_idx]  <= miss_tag;
    end
  end

  // Registered copy of the last hit word, presented while stalled
  always_ff @(posedge clk) begin
    if (reset)                           held <= '0;
    else if (state == S_IDLE && hit)     held <= hit_word;
  end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus pushes expected fetch results,
// a negedge monitor pops and checks them when the cache stops stalling.
`timescale 1ns/1ps
module tb_instr_cache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addr = '0;
  logic [31:0]  out;
  logic         clk_stall;
  logic [8:0]   mem_block_addr;
  logic [255:0] new_line = '0;
  logic         readmem;

  instr_cache #(.NUM_LINES(16), .BLOCK_AW(9)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .out            (out),
    .clk_stall      (clk_stall),
    .mem_block_addr (mem_block_addr),
    .new_line       (new_line),
    .readmem        (readmem)
  );

  always #1 clk = ~clk;

  // Main memory: word n = A000_0000 + n; registered line read
  function automatic logic [255:0] mem_line(input logic [8:0] b);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[32*k +: 32] = 32'hA000_0000 + {20'd0, b, 3'd0} + 32'(k);
    return l;
  endfunction

  always @(posedge clk) if (readmem) new_line <= mem_line(mem_block_addr);

  typedef struct {
    logic [31:0] data;
    int          stalls;
    int          blk;
  } exp_t;

  exp_t sb[$];
  int   issued = 0;
  int   completed = 0;
  int   checks = 0;
  int   errs = 0;
  int   stall_cnt = 0;
  int   blk_seen = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count stall cycles, note the requested block, check on release
  always @(negedge clk) begin
    exp_t e;
    if (completed < issued && !reset) begin
      if (clk_stall) begin
        stall_cnt++;
        if (readmem && blk_seen < 0) blk_seen = int'(mem_block_addr);
      end else begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
          e = sb.pop_front();
          chk("out", out, e.data);
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          if (e.stalls > 0) chk("mem_block_addr", 32'(blk_seen), 32'(e.blk));
        end
        stall_cnt = 0;
        blk_seen  = -1;
        completed++;
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #0.2;
  endtask

  task automatic summary_and_finish();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  endtask

  // Issue a fetch; optionally switch addr after sw_after cycles of stall
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int stalls,
                       input int blk, input int sw_after, input logic [31:0] a2);
    exp_t e;
    int   n;
    e.data = exp; e.stalls = stalls; e.blk = blk;
    sb.push_back(e);
    addr = a;
    issued++;
    n = 0;
    while (completed < issued && n < 40) begin
      drive_slot();
      n++;
      if (sw_after > 0 && n == sw_after) addr = a2;
    end
    if (completed < issued) begin
      checks++;
      errs++;
      $display("FAIL timeout: got no response for addr %h expected %h", a, exp);
      summary_and_finish();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) drive_slot();
    @(negedge clk);
    chk("reset_readmem", 32'(readmem), 32'd0);
    chk("reset_stall", 32'(clk_stall), 32'd0);
    chk("reset_out", out, 32'h0);
    drive_slot();
    reset = 1'b0;

    // 1: cold miss
    fetch(32'h0, 32'hA000_0000, 4, 0, 0, 32'h0);
    // 2: same-line hits
    for (int a = 1; a <= 15; a++)
      fetch(32'(a), 32'hA000_0000 + 32'(a / 4), 0, 0, 0, 32'h0);
    fetch(32'h1C, 32'hA000_0007, 0, 0, 0, 32'h0);
    // 3: new line, then old line still hits
    fetch(32'h20, 32'hA000_0008, 4, 1, 0, 32'h0);
    fetch(32'h3C, 32'hA000_000F, 0, 0, 0, 32'h0);
    fetch(32'h0, 32'hA000_0000, 0, 0, 0, 32'h0);
    // 4: conflict on index 0, then original line refills
    fetch(32'h200, 32'hA000_0080, 4, 16, 0, 32'h0);
    fetch(32'h0, 32'hA000_0000, 4, 0, 0, 32'h0);
    // High address bits and byte offset are ignored
    fetch(32'hFFFF_C003, 32'hA000_0000, 0, 0, 0, 32'h0);
    // 5: addr switched to 0x60 during WAIT; 0x40 line filled, 0x60 misses
    fetch(32'h40, 32'hA000_0018, 8, 2, 2, 32'h60);
    fetch(32'h44, 32'hA000_0011, 0, 0, 0, 32'h0);
    // 6: reset during WAIT aborts the fill
    addr = 32'h80;
    drive_slot();
    drive_slot();
    @(negedge clk);
    chk("wait_readmem", 32'(readmem), 32'd1);
    chk("wait_blk", 32'(mem_block_addr), 32'd4);
    #0.2;
    reset = 1'b1;
    drive_slot();
    @(negedge clk);
    chk("abort_readmem", 32'(readmem), 32'd0);
    chk("abort_stall", 32'(clk_stall), 32'd0);
    drive_slot();
    reset = 1'b0;
    fetch(32'h80, 32'hA000_0020, 4, 4, 0, 32'h0);
    // Lines filled before reset are invalid again
    fetch(32'h0, 32'hA000_0000, 4, 0, 0, 32'h0);
    summary_and_finish();
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish expected finish before 20000ns");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

endmodule
